// File: rtl/spi_boot_sequencer_if.sv
// Byte-stream, transmit and instruction-memory signals of the SPI boot sequencer.
// The master side drives received bytes; the slave side is the sequencer.
interface spi_boot_if #(
   parameter int ADDR_W = 4
);
   logic [7:0]        rx_byte;
   logic              rx_valid;
   logic [7:0]        tx_byte;
   logic              tx_valid;
   logic              imem_wr_en;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_rst_n;
   logic              busy;
   logic              done;
   logic [1:0]        err_code;

   modport master (
      output rx_byte, rx_valid,
      input  tx_byte, tx_valid, imem_wr_en, imem_addr, imem_wdata,
      input  cpu_rst_n, busy, done, err_code
   );

   modport slave (
      input  rx_byte, rx_valid,
      output tx_byte, tx_valid, imem_wr_en, imem_addr, imem_wdata,
      output cpu_rst_n, busy, done, err_code
   );
endinterface

// File: rtl/spi_boot_sequencer.sv
// SPI boot sequencer: decodes SYNC/RUN/HALT commands and burst-load frames from
// the received byte stream, writes 32-bit little-endian words to consecutive
// instruction-memory addresses, verifies an XOR checksum and answers ACK/NAK.
module spi_boot_sequencer #(
   parameter int ADDR_W      = 4,
   parameter int TIMEOUT_CYC = 4096
) (
   input logic       clk,
   input logic       rst_n,
   spi_boot_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

   localparam logic [7:0] CMD_SYNC = 8'hA5;
   localparam logic [7:0] CMD_RUN  = 8'h5A;
   localparam logic [7:0] CMD_HALT = 8'h3C;
   localparam logic [7:0] RSP_ACK  = 8'h06;
   localparam logic [7:0] RSP_NAK  = 8'h15;

   typedef enum logic [2:0] {S_IDLE, S_ADDR, S_COUNT, S_DATA, S_CHK} state_t;

   state_t            state_q;
   logic [TMR_W-1:0]  tmr_q;
   logic [1:0]        byte_idx_q;
   logic [ADDR_W:0]   words_left_q;
   logic [ADDR_W-1:0] waddr_q;
   logic [23:0]       wbuf_q;
   logic [7:0]        chk_q;

   logic [7:0]        tx_byte_q;
   logic              tx_valid_q;
   logic              wr_en_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic              cpu_rst_n_q;
   logic              done_q;
   logic [1:0]        err_q;

   logic [31:0]       word_d;
   logic [7:0]        chk_d;
   logic              bad_count_d;
   logic              timeout_d;

   // Assembled word, running checksum, count validity and inter-byte timeout expiry
   always_comb begin
      word_d      = {bus.rx_byte, wbuf_q};
      chk_d       = chk_q ^ bus.rx_byte;
      bad_count_d = (bus.rx_byte == 8'd0) || (int'(bus.rx_byte) > DEPTH);
      timeout_d   = (state_q != S_IDLE) && !bus.rx_valid &&
                    (tmr_q == TMR_W'(TIMEOUT_CYC - 1));
   end

   // Frame datapath: write address, remaining word count, partial word and checksum
   always_ff @(posedge clk) begin
      if (bus.rx_valid) begin
         case (state_q)
            S_ADDR: begin
               waddr_q <= bus.rx_byte[ADDR_W-1:0];
               chk_q   <= bus.rx_byte;
            end
            S_COUNT: begin
               words_left_q <= (ADDR_W + 1)'(bus.rx_byte);
               chk_q        <= chk_d;
            end
            S_DATA: begin
               chk_q <= chk_d;
               case (byte_idx_q)
                  2'd0: wbuf_q[7:0]   <= bus.rx_byte;
                  2'd1: wbuf_q[15:8]  <= bus.rx_byte;
                  2'd2: wbuf_q[23:16] <= bus.rx_byte;
                  default: begin
                     waddr_q      <= waddr_q + 1'b1;
                     words_left_q <= words_left_q - 1'b1;
                  end
               endcase
            end
            default: ;
         endcase
      end
   end

   // Control FSM with registered outputs; a byte always takes priority over timeout
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         tmr_q       <= '0;
         byte_idx_q  <= '0;
         tx_byte_q   <= '0;
         tx_valid_q  <= 1'b0;
         wr_en_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         cpu_rst_n_q <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 2'b00;
      end else begin
         tx_valid_q <= 1'b0;
         wr_en_q    <= 1'b0;
         if (state_q != S_IDLE) begin
            tmr_q <= bus.rx_valid ? '0 : tmr_q + 1'b1;
         end
         if (timeout_d) begin
            err_q      <= 2'b11;
            tx_byte_q  <= RSP_NAK;
            tx_valid_q <= 1'b1;
            state_q    <= S_IDLE;
         end else if (bus.rx_valid) begin
            case (state_q)
               S_IDLE: begin
                  case (bus.rx_byte)
                     CMD_SYNC: begin
                        state_q     <= S_ADDR;
                        tmr_q       <= '0;
                        cpu_rst_n_q <= 1'b0;
                        done_q      <= 1'b0;
                        err_q       <= 2'b00;
                     end
                     CMD_RUN:  cpu_rst_n_q <= 1'b1;
                     CMD_HALT: cpu_rst_n_q <= 1'b0;
                     default: ;
                  endcase
               end
               S_ADDR: state_q <= S_COUNT;
               S_COUNT: begin
                  if (bad_count_d) begin
                     err_q      <= 2'b01;
                     tx_byte_q  <= RSP_NAK;
                     tx_valid_q <= 1'b1;
                     state_q    <= S_IDLE;
                  end else begin
                     byte_idx_q <= '0;
                     state_q    <= S_DATA;
                  end
               end
               S_DATA: begin
                  byte_idx_q <= byte_idx_q + 1'b1;
                  if (byte_idx_q == 2'd3) begin
                     wr_en_q <= 1'b1;
                     addr_q  <= waddr_q;
                     wdata_q <= word_d;
                     if (words_left_q == (ADDR_W + 1)'(1)) begin
                        state_q <= S_CHK;
                     end
                  end
               end
               S_CHK: begin
                  if (bus.rx_byte == chk_q) begin
                     done_q    <= 1'b1;
                     tx_byte_q <= RSP_ACK;
                  end else begin
                     err_q     <= 2'b10;
                     tx_byte_q <= RSP_NAK;
                  end
                  tx_valid_q <= 1'b1;
                  state_q    <= S_IDLE;
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.tx_byte    = tx_byte_q;
   assign bus.tx_valid   = tx_valid_q;
   assign bus.imem_wr_en = wr_en_q;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = wdata_q;
   assign bus.cpu_rst_n  = cpu_rst_n_q;
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.done       = done_q;
   assign bus.err_code   = err_q;
endmodule

// File: tb/tb_spi_boot_sequencer.sv
// Self-checking bench for spi_boot_sequencer: a frame-position reference model
// predicts every output each cycle; directed scenarios pin literal values.
module tb_spi_boot_sequencer;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 16;
   localparam int TO     = 16;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   spi_boot_if #(.ADDR_W(ADDR_W)) bus ();

   spi_boot_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   logic              in_frame;
   logic [7:0]        fb[$];
   int                gap;
   logic [7:0]        e_tx_byte;
   logic              e_tx_valid;
   logic              e_wr;
   logic [ADDR_W-1:0] e_addr;
   logic [31:0]       e_wdata;
   logic              e_cpu;
   logic              e_done;
   logic [1:0]        e_err;

   // observed write / response log
   logic [ADDR_W-1:0] wa_log[$];
   logic [31:0]       wd_log[$];
   int                tx_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      in_frame   = 1'b0;
      fb.delete();
      gap        = 0;
      e_tx_byte  = 8'h00;
      e_tx_valid = 1'b0;
      e_wr       = 1'b0;
      e_addr     = '0;
      e_wdata    = 32'h0;
      e_cpu      = 1'b0;
      e_done     = 1'b0;
      e_err      = 2'b00;
   endtask

   task automatic respond(input logic [7:0] b, input logic [1:0] err);
      e_tx_byte  = b;
      e_tx_valid = 1'b1;
      e_err      = err;
      in_frame   = 1'b0;
   endtask

   // Frame interpreted by byte position after SYNC: 1 addr, 2 count,
   // 3..2+4*count data, then checksum.
   task automatic model_step(input logic v, input logic [7:0] b);
      int n;
      int cnt;
      logic [7:0] x;
      e_tx_valid = 1'b0;
      e_wr       = 1'b0;
      if (!in_frame) begin
         if (v) begin
            if (b == 8'hA5) begin
               in_frame = 1'b1;
               fb.delete();
               gap    = 0;
               e_cpu  = 1'b0;
               e_done = 1'b0;
               e_err  = 2'b00;
            end else if (b == 8'h5A) e_cpu = 1'b1;
            else if (b == 8'h3C) e_cpu = 1'b0;
         end
      end else if (v) begin
         gap = 0;
         fb.push_back(b);
         n = fb.size();
         if (n == 2) begin
            if (b == 8'd0 || int'(b) > DEPTH) respond(8'h15, 2'b01);
         end else if (n > 2) begin
            cnt = int'(fb[1]);
            if (n <= 2 + 4 * cnt) begin
               if ((n - 2) % 4 == 0) begin
                  e_wr    = 1'b1;
                  e_addr  = ADDR_W'((int'(fb[0]) + (n - 3) / 4) % DEPTH);
                  e_wdata = {fb[n-1], fb[n-2], fb[n-3], fb[n-4]};
               end
            end else begin
               x = 8'h00;
               for (int i = 0; i < n - 1; i++) x = x ^ fb[i];
               if (b == x) begin
                  e_done = 1'b1;
                  respond(8'h06, e_err);
               end else begin
                  respond(8'h15, 2'b10);
               end
            end
         end
      end else begin
         gap++;
         if (gap >= TO) respond(8'h15, 2'b11);
      end
   endtask

   // model advances on every active edge, resets asynchronously with the DUT
   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else model_step(bus.rx_valid, bus.rx_byte);
      end
   end

   // compare DUT against model on the falling edge, and log writes/responses
   initial begin
      forever begin
         @(negedge clk);
         check("tx_valid",   32'(bus.tx_valid),   32'(e_tx_valid));
         check("tx_byte",    32'(bus.tx_byte),    32'(e_tx_byte));
         check("imem_wr_en", 32'(bus.imem_wr_en), 32'(e_wr));
         check("imem_addr",  32'(bus.imem_addr),  32'(e_addr));
         check("imem_wdata", bus.imem_wdata,      e_wdata);
         check("cpu_rst_n",  32'(bus.cpu_rst_n),  32'(e_cpu));
         check("busy",       32'(bus.busy),       32'(in_frame));
         check("done",       32'(bus.done),       32'(e_done));
         check("err_code",   32'(bus.err_code),   32'(e_err));
         if (bus.imem_wr_en === 1'b1) begin
            wa_log.push_back(bus.imem_addr);
            wd_log.push_back(bus.imem_wdata);
         end
         if (bus.tx_valid === 1'b1) tx_cnt++;
      end
   end

   task automatic send(input logic [7:0] b);
      bus.rx_byte  = b;
      bus.rx_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_word(input logic [31:0] w);
      send(w[7:0]);
      send(w[15:8]);
      send(w[23:16]);
      send(w[31:24]);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_tx_byte"},  32'(bus.tx_byte),    32'h00);
      check({tag, "_tx_valid"}, 32'(bus.tx_valid),   32'h0);
      check({tag, "_wr_en"},    32'(bus.imem_wr_en), 32'h0);
      check({tag, "_addr"},     32'(bus.imem_addr),  32'h0);
      check({tag, "_wdata"},    bus.imem_wdata,      32'h0);
      check({tag, "_cpu"},      32'(bus.cpu_rst_n),  32'h0);
      check({tag, "_busy"},     32'(bus.busy),       32'h0);
      check({tag, "_done"},     32'(bus.done),       32'h0);
      check({tag, "_err"},      32'(bus.err_code),   32'h0);
   endtask

   initial begin
      int base;
      int tbase;
      logic [7:0] addr;
      logic [7:0] cnt;
      logic [7:0] x;
      logic [7:0] d;
      int kind;
      int stall_at;
      bit aborted;

      bus.rx_byte  = 8'h00;
      bus.rx_valid = 1'b0;
      idle(3);
      check_reset_values("rst");
      rst_n = 1'b1;
      idle(2);

      // single-word frame, then RUN
      base = wa_log.size();
      send(8'hA5); send(8'h02); send(8'h01);
      send_word(32'h0000_0013);
      send(8'h10);
      check("t1_nwr",    32'(wa_log.size() - base), 32'd1);
      check("t1_addr",   32'(wa_log[base]),         32'd2);
      check("t1_wdata",  wd_log[base],              32'h0000_0013);
      check("t1_tx",     32'(bus.tx_byte),          32'h06);
      check("t1_txv",    32'(bus.tx_valid),         32'h1);
      check("t1_done",   32'(bus.done),             32'h1);
      check("t1_cpu",    32'(bus.cpu_rst_n),        32'h0);
      check("t1_mdone",  32'(e_done),               32'h1);
      send(8'h5A);
      check("t1_run",    32'(bus.cpu_rst_n),        32'h1);
      check("t1_mcpu",   32'(e_cpu),                32'h1);
      idle(2);

      // address wrap 15 -> 0
      base = wa_log.size();
      send(8'hA5); send(8'h0F); send(8'h02);
      send_word(32'h1111_1111);
      send_word(32'h2222_2222);
      send(8'h0D);
      check("t2_nwr",    32'(wa_log.size() - base), 32'd2);
      check("t2_addr0",  32'(wa_log[base]),         32'd15);
      check("t2_addr1",  32'(wa_log[base+1]),       32'd0);
      check("t2_wd1",    wd_log[base+1],            32'h2222_2222);
      check("t2_tx",     32'(bus.tx_byte),          32'h06);
      idle(1);

      // bad checksum, write kept
      base = wa_log.size();
      send(8'hA5); send(8'h02); send(8'h01);
      send_word(32'h0000_0013);
      send(8'h11);
      check("t3_nwr",    32'(wa_log.size() - base), 32'd1);
      check("t3_tx",     32'(bus.tx_byte),          32'h15);
      check("t3_err",    32'(bus.err_code),         32'h2);
      check("t3_done",   32'(bus.done),             32'h0);
      check("t3_merr",   32'(e_err),                32'h2);
      send(8'hA5);
      check("t3_clr",    32'(bus.err_code),         32'h0);

      // count 0 and count 17 rejected
      base = wa_log.size();
      send(8'h00); send(8'h00);
      check("t4a_tx",    32'(bus.tx_byte),          32'h15);
      check("t4a_txv",   32'(bus.tx_valid),         32'h1);
      check("t4a_err",   32'(bus.err_code),         32'h1);
      send(8'hA5); send(8'h00); send(8'h11);
      check("t4b_tx",    32'(bus.tx_byte),          32'h15);
      check("t4b_err",   32'(bus.err_code),         32'h1);
      check("t4_nwr",    32'(wa_log.size() - base), 32'd0);
      idle(1);

      // timeout after a partial word
      base = wa_log.size();
      send(8'hA5); send(8'h03); send(8'h01); send(8'hAA);
      idle(TO);
      check("t5_txv",    32'(bus.tx_valid),         32'h1);
      check("t5_tx",     32'(bus.tx_byte),          32'h15);
      check("t5_err",    32'(bus.err_code),         32'h3);
      check("t5_busy",   32'(bus.busy),             32'h0);
      check("t5_nwr",    32'(wa_log.size() - base), 32'd0);
      idle(1);

      // byte arriving on the expiry cycle wins
      send(8'hA5); send(8'h03); send(8'h01); send(8'hAA);
      idle(TO - 1);
      check("t5b_busy0", 32'(bus.busy),             32'h1);
      send(8'hBB);
      check("t5b_err",   32'(bus.err_code),         32'h0);
      check("t5b_busy",  32'(bus.busy),             32'h1);
      send(8'hCC); send(8'hDD); send(8'h02);
      check("t5b_tx",    32'(bus.tx_byte),          32'h06);
      check("t5b_done",  32'(bus.done),             32'h1);
      idle(1);

      // asynchronous reset between data bytes 2 and 3
      send(8'hA5); send(8'h05); send(8'h01); send(8'h11); send(8'h22);
      #3;
      rst_n = 1'b0;
      #1;
      check_reset_values("arst");
      idle(2);
      rst_n = 1'b1;
      base  = wa_log.size();
      tbase = tx_cnt;
      send(8'h33);
      idle(4);
      check("t6_nwr",    32'(wa_log.size() - base), 32'd0);
      check("t6_ntx",    32'(tx_cnt - tbase),       32'd0);

      // randomized frames against the model
      for (int f = 0; f < 60; f++) begin
         kind = $urandom_range(0, 9);
         if ($urandom_range(0, 2) == 0) begin
            case ($urandom_range(0, 2))
               0: send(8'h5A);
               1: send(8'h3C);
               default: begin
                  d = 8'($urandom_range(0, 255));
                  if (d == 8'hA5) d = 8'h00;
                  send(d);
               end
            endcase
            idle($urandom_range(0, 2));
         end
         addr = 8'($urandom_range(0, 255));
         if (kind == 0)
            cnt = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(DEPTH + 1, 255));
         else
            cnt = 8'($urandom_range(1, DEPTH));
         send(8'hA5);
         idle($urandom_range(0, 2));
         send(addr);
         idle($urandom_range(0, 2));
         send(cnt);
         if (kind == 0) continue;
         x = addr ^ cnt;
         stall_at = (kind == 1) ? $urandom_range(0, 4 * int'(cnt) - 1) : -1;
         aborted = 1'b0;
         for (int i = 0; i < 4 * int'(cnt); i++) begin
            idle($urandom_range(0, 2));
            d = 8'($urandom_range(0, 255));
            x = x ^ d;
            send(d);
            if (i == stall_at) begin
               idle(TO + 2);
               aborted = 1'b1;
               break;
            end
         end
         if (aborted) continue;
         idle($urandom_range(0, 2));
         if (kind == 2) send(x ^ 8'($urandom_range(1, 255)));
         else send(x);
         idle($urandom_range(0, 3));
      end
      idle(4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
